write_back_buffer: RTL and testbench

Elastic buffer between the `write_back` masking stage and the vector register file (VRF) write port. It accepts the merged `vd_write_back` packet (tag plus 64-bit data), holds it in an in-order circular queue, and retires one packet per cycle to the VRF under a valid/ready handshake. It also answers pending-write hazard queries by tag, so issue logic can stall or forward data from results not yet committed.

---
 rtl/write_back_buffer.sv | 116 +++++++++++
 tb/tb_write_back_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/write_back_buffer.sv
// ============================================================================
// Module   : write_back_buffer (with package dragonfang_pkg)
// Brief    : In-order elastic queue from write_back to the VRF write port, with
//            tag-based pending-write lookup. Optional zero-latency bypass under
//            macro DRAGONFANG_WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dragonfang_pkg;
    typedef struct packed {
        logic [4:0]  tag;
        logic [63:0] data;
    } data_packet_t;
endpackage

module write_back_buffer
    import dragonfang_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  data_packet_t               vd_write_back,
    output logic                       vrf_we,
    input  logic                       vrf_ready,
    output data_packet_t               vrf_write_packet,
    input  logic [TAG_WIDTH-1:0]       lookup_tag,
    output logic                       lookup_hit,
    output logic [DATA_WIDTH-1:0]      lookup_data,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    data_packet_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0]       r_wptr;
    logic [c_PTR_W-1:0]       r_rptr;
    logic [c_CNT_W-1:0]       r_count;

    logic                     w_empty;
    logic                     w_bypass;
    logic                     w_push;
    logic                     w_pop;

    assign w_empty  = (r_count == '0);
    assign wb_ready = (r_count != c_CNT_W'(DEPTH));
    assign occupancy = r_count;

`ifdef DRAGONFANG_WB_BYPASS_EN
    // An empty queue forwards the incoming packet; it is only consumed
    // without storage when the VRF takes it in the same cycle.
    assign w_bypass         = w_empty && !flush && wb_valid && vrf_ready;
    assign vrf_we           = !flush && (!w_empty || wb_valid);
    assign vrf_write_packet = w_empty ? vd_write_back : r_mem[r_rptr];
`else
    assign w_bypass         = 1'b0;
    assign vrf_we           = !w_empty && !flush;
    assign vrf_write_packet = r_mem[r_rptr];
`endif

    assign w_push = wb_valid && wb_ready && !flush && !w_bypass;
    assign w_pop  = vrf_we && vrf_ready && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= vd_write_back;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [c_PTR_W-1:0] idx;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + i[c_PTR_W-1:0];
            if ((c_CNT_W'(i) < r_count) && (r_mem[idx].tag == lookup_tag)) begin
                lookup_hit  = 1'b1;
                lookup_data = r_mem[idx].data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_write_back_buffer.sv
// ============================================================================
// Module   : tb_write_back_buffer
// Brief    : Randomised and directed scoreboard bench for write_back_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_write_back_buffer;
    import dragonfang_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    data_packet_t  vd_write_back = '0;
    logic          vrf_we;
    logic          vrf_ready = 1'b0;
    data_packet_t  vrf_write_packet;
    logic [4:0]    lookup_tag = '0;
    logic          lookup_hit;
    logic [63:0]   lookup_data;
    logic [2:0]    occupancy;

    int checks = 0;
    int errors = 0;

    // Expected queue contents, oldest first.
    data_packet_t  q[$];

    write_back_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(5), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .vd_write_back(vd_write_back),
        .vrf_we(vrf_we), .vrf_ready(vrf_ready), .vrf_write_packet(vrf_write_packet),
        .lookup_tag(lookup_tag), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT against the queue model mid-cycle, then applies
    // the transfer that the coming rising edge will commit.
    always @(negedge clk) begin
        if (rst_n) begin
            int           cnt;
            logic         exp_we, exp_hit, byp, pop, push;
            logic [63:0]  exp_ld;
            data_packet_t exp_pkt;
            cnt     = q.size();
            byp     = 1'b0;
            exp_we  = (cnt != 0) && !flush;
            exp_pkt = (cnt != 0) ? q[0] : '0;
`ifdef DRAGONFANG_WB_BYPASS_EN
            if (cnt == 0) begin
                exp_we  = !flush && wb_valid;
                exp_pkt = vd_write_back;
                byp     = !flush && wb_valid && vrf_ready;
            end
`endif
            exp_hit = 1'b0;
            exp_ld  = '0;
            for (int i = cnt - 1; i >= 0; i--) begin
                if (!exp_hit && q[i].tag == lookup_tag) begin
                    exp_hit = 1'b1;
                    exp_ld  = q[i].data;
                end
            end
            check("occupancy", 128'(occupancy), 128'(cnt));
            check("wb_ready", 128'(wb_ready), 128'(cnt != DEPTH));
            check("vrf_we", 128'(vrf_we), 128'(exp_we));
            if (exp_we && vrf_we) check("vrf_packet", 128'(vrf_write_packet), 128'(exp_pkt));
            check("lookup_hit", 128'(lookup_hit), 128'(exp_hit));
            check("lookup_data", 128'(lookup_data), 128'(exp_ld));

            if (flush) begin
                q.delete();
            end else begin
                pop  = exp_we && vrf_ready && (cnt != 0);
                push = wb_valid && (cnt != DEPTH) && !byp;
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(vd_write_back);
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] tag, input logic [63:0] data,
                         input logic rdy, input logic fl, input logic [4:0] lt);
        wb_valid      = v;
        vd_write_back = '{tag: tag, data: data};
        vrf_ready     = rdy;
        flush         = fl;
        lookup_tag    = lt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_vrf_we", 128'(vrf_we), 128'(0));
        check("rst_occ", 128'(occupancy), 128'(0));
        check("rst_wb_ready", 128'(wb_ready), 128'(1));
        check("rst_hit", 128'(lookup_hit), 128'(0));
        check("rst_ldata", 128'(lookup_data), 128'(0));
`ifndef DRAGONFANG_WB_BYPASS_EN
        check("rst_packet", 128'(vrf_write_packet), 128'(0));
`endif
    endtask

    initial begin
        #13;
        check_reset_outputs();
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single push with the VRF ready.
        drive(1, 5'd3, 64'hDEAD_BEEF_0123_4567, 1, 0, 5'd3);
        drive(0, 0, 0, 1, 0, 5'd3);
        drive(0, 0, 0, 1, 0, 5'd3);

        // Fill with back-pressure, try a fifth push, then drain.
        for (int t = 1; t <= 5; t++) drive(1, 5'(t), 64'(t * 64'h1111), 0, 0, 5'(t));
        for (int t = 0; t < 5; t++) drive(0, 0, 0, 1, 0, 5'd4);

        // Streamed wrap-around.
        for (int t = 0; t < 10; t++) drive(1, 5'(t), 64'(t) << 8, 1, 0, 5'(t));
        drive(0, 0, 0, 1, 0, 0);

        // Duplicate-tag lookup: youngest wins; absent tag misses.
        drive(1, 5'd5, 64'hAAAA, 0, 0, 5'd5);
        drive(1, 5'd5, 64'hBBBB, 0, 0, 5'd5);
        drive(0, 0, 0, 0, 0, 5'd5);
        drive(0, 0, 0, 0, 0, 5'd6);
        for (int t = 0; t < 3; t++) drive(0, 0, 0, 1, 0, 5'd5);

        // Flush with a concurrent push and three entries queued.
        for (int t = 0; t < 3; t++) drive(1, 5'(20 + t), 64'(t + 100), 0, 0, 5'd21);
        drive(1, 5'd30, 64'hF00D, 1, 1, 5'd30);
        for (int t = 0; t < 3; t++) drive(0, 0, 0, 1, 0, 5'd30);

        // Asynchronous reset between edges with two entries queued.
        drive(1, 5'd7, 64'h77, 0, 0, 5'd7);
        drive(1, 5'd8, 64'h88, 0, 0, 5'd8);
        wb_valid = 1'b0;
        lookup_tag = 5'd7;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check_reset_outputs();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) drive(0, 0, 0, 1, 0, 5'd7);

        // Randomised traffic.
        for (int t = 0; t < 400; t++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, 5'($urandom_range(0, 7)));
        end
        for (int t = 0; t < 6; t++) drive(0, 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
